// File: rtl/prog_loader.sv
// =============================================================================
// Module   : prog_loader
// Purpose  : Byte-stream program loader; writes 16-bit words into CPU instruction
//            memory and holds the CPU in reset while a frame is loading.
// Options  : PROG_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module prog_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [15:0]       o_instr,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNT   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6,
    S_CHK   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_instr;
  logic [ADDR_W-1:0]   r_addr;
  logic [8:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_cpu_rst;
  logic                w_acc;
  logic                w_hdr;
  logic                w_last;

  assign w_acc  = i_valid && o_ready;
  assign w_hdr  = w_acc && (i_byte == HDR_BYTE);
  assign w_last = (r_cnt == 9'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic       w_sum_ok;
  assign w_sum_ok = (i_byte == r_sum);
  assign o_err    = r_err;
`else
  assign o_err    = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    o_ready = (r_state != S_WRITE);
    o_we    = (r_state == S_WRITE);
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_hdr) w_next = S_CNT;
      S_CNT:   if (w_acc) w_next = S_HI;
      S_HI:    if (w_acc) w_next = S_LO;
      S_LO:    if (w_acc) w_next = S_WRITE;
      S_WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        w_next = w_last ? S_CHK : S_HI;
`else
        w_next = w_last ? S_DONE : S_HI;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:   if (w_acc) w_next = w_sum_ok ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= 16'h0000;
      r_addr    <= '0;
      r_cnt     <= 9'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cpu_rst <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_sum     <= 8'h00;
      r_err     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_hdr) begin
            r_busy    <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_addr    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum     <= 8'h00;
            r_err     <= 1'b0;
`endif
          end
        end
        // A count byte of zero encodes a full 256-word frame.
        S_CNT: if (w_acc) r_cnt <= (i_byte == 8'h00) ? 9'd256 : {1'b0, i_byte};
        S_HI: begin
          if (w_acc) begin
            r_instr[15:8] <= i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum         <= r_sum + i_byte;
`endif
          end
        end
        S_LO: begin
          if (w_acc) begin
            r_instr[7:0] <= i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum        <= r_sum + i_byte;
`endif
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_cnt  <= r_cnt - 9'd1;
`ifndef PROG_LOADER_CHECKSUM_EN
          if (w_last) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        // A bad checksum leaves the CPU held in reset.
        S_CHK: begin
          if (w_acc) begin
            r_busy <= 1'b0;
            if (w_sum_ok) begin
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_err     <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign o_instr   = r_instr;
  assign o_addr    = r_addr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cpu_rst = r_cpu_rst;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// =============================================================================
// Module   : tb_prog_loader
// Purpose  : Scoreboard bench for prog_loader; expected writes are queued as
//            bytes are driven and popped when o_we is seen.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_instr;
  logic        o_we;
  logic [7:0]  o_addr;
  logic        o_cpu_rst;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass;
  int  n_total;
  int  n_writes;

  prog_loader #(.ADDR_W(8), .HDR_BYTE(8'hA5)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_byte    (i_byte),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_instr   (o_instr),
    .o_we      (o_we),
    .o_addr    (o_addr),
    .o_cpu_rst (o_cpu_rst),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: each o_we pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && o_we) begin
      wr_t e;
      n_writes++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%02h data=%04h, required no write", o_addr, o_instr);
      end else begin
        e = exp_q.pop_front();
        if (o_addr !== e.a || o_instr !== e.d)
          $display("FAIL write: got addr=%02h data=%04h, required addr=%02h data=%04h",
                   o_addr, o_instr, e.a, e.d);
        else
          n_pass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    i_byte  = b;
    i_valid = 1'b1;
    k = 0;
    while (!o_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) begin
      n_total++;
      $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, required 1", o_ready, k);
    end
    @(posedge clk); #1;
  endtask

  // Sends a complete frame; words beyond index 1 are random.
  task automatic send_frame(input int n, input logic [15:0] w0, input logic [15:0] w1,
                            input bit bad_sum);
    logic [7:0]  sum;
    logic [15:0] w;
    sum = 8'h00;
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : 16'($urandom);
      exp_q.push_back('{a: 8'(i), d: w});
      sum = sum + w[15:8] + w[7:0];
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(bad_sum ? sum + 8'h01 : sum);
    i_valid = 1'b0;
`else
    if (bad_sum) sum = 8'h00;
    i_valid = 1'b0;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({o_we, o_addr, o_instr, o_cpu_rst, o_busy, o_done, o_err, o_ready} !== {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values: got we=%0b addr=%02h instr=%04h cpu_rst=%0b busy=%0b done=%0b err=%0b ready=%0b, required 0 00 0000 1 0 0 0 1",
               o_we, o_addr, o_instr, o_cpu_rst, o_busy, o_done, o_err, o_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    exp_q.push_back('{a: 8'h00, d: 16'h1234});
    exp_q.push_back('{a: 8'h01, d: 16'hABCD});
    send_byte(8'hA5);
    n_total++;
    if (o_busy !== 1'b1 || o_cpu_rst !== 1'b1)
      $display("FAIL basic_busy: got busy=%0b cpu_rst=%0b, required 1 1", o_busy, o_cpu_rst);
    else n_pass++;
    exp_q.delete();
    send_frame_tail_basic();
    n_total++;
    if (o_done !== 1'b1 || o_cpu_rst !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL basic_done: got done=%0b cpu_rst=%0b busy=%0b, required 1 0 0", o_done, o_cpu_rst, o_busy);
    else n_pass++;
    n_total++;
    if (o_addr !== 8'h02)
      $display("FAIL basic_addr: got %02h, required 02", o_addr);
    else n_pass++;
  endtask

  // Remainder of the basic frame after the header has been checked.
  task automatic send_frame_tail_basic;
    logic [7:0] sum;
    exp_q.push_back('{a: 8'h00, d: 16'h1234});
    exp_q.push_back('{a: 8'h01, d: 16'hABCD});
    sum = 8'h12 + 8'h34 + 8'hAB + 8'hCD;
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(sum);
    i_valid = 1'b0;
`else
    if (sum == 8'h00) sum = 8'h01;
    i_valid = 1'b0;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_garbage;
    int w0;
    w0 = n_writes;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    i_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (o_busy !== 1'b0 || n_writes !== w0)
      $display("FAIL garbage_ignored: got busy=%0b writes=%0d, required 0 %0d", o_busy, n_writes, w0);
    else n_pass++;
    send_frame(1, 16'h0007, 16'h0000, 1'b0);
    n_total++;
    if (n_writes !== w0 + 1 || o_done !== 1'b1)
      $display("FAIL garbage_frame: got writes=%0d done=%0b, required %0d 1", n_writes, o_done, w0 + 1);
    else n_pass++;
  endtask

  task automatic test_full256;
    int w0;
    w0 = n_writes;
    send_frame(256, 16'hA5A5, 16'h00A5, 1'b0);
    n_total++;
    if (n_writes !== w0 + 256)
      $display("FAIL full_count: got %0d writes, required 256", n_writes - w0);
    else n_pass++;
    n_total++;
    if (o_addr !== 8'h00 || o_done !== 1'b1 || o_cpu_rst !== 1'b0)
      $display("FAIL full_end: got addr=%02h done=%0b cpu_rst=%0b, required 00 1 0", o_addr, o_done, o_cpu_rst);
    else n_pass++;
  endtask

  task automatic test_stall;
    int w0;
    w0 = n_writes;
    exp_q.push_back('{a: 8'h00, d: 16'hBEEF});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hBE);
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (o_we !== 1'b0 || o_instr[15:8] !== 8'hBE || n_writes !== w0)
        $display("FAIL stall_hold: cycle %0d got we=%0b hi=%02h, required 0 be", c, o_we, o_instr[15:8]);
      else n_pass++;
    end
    send_byte(8'hEF);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'hBE + 8'hEF);
    i_valid = 1'b0;
`else
    i_valid = 1'b0;
    @(posedge clk); #1;
`endif
    n_total++;
    if (n_writes !== w0 + 1 || o_done !== 1'b1)
      $display("FAIL stall_write: got writes=%0d done=%0b, required %0d 1", n_writes - w0, o_done, 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    exp_q.push_back('{a: 8'h00, d: 16'h1122});
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_we, o_addr, o_instr, o_cpu_rst, o_busy, o_done, o_err} !== {1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_mid: got we=%0b addr=%02h instr=%04h cpu_rst=%0b busy=%0b done=%0b err=%0b, required 0 00 0000 1 0 0 0",
               o_we, o_addr, o_instr, o_cpu_rst, o_busy, o_done, o_err);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(1, 16'h1122, 16'h0000, 1'b0);
    n_total++;
    if (o_done !== 1'b1 || o_addr !== 8'h01)
      $display("FAIL reset_reload: got done=%0b addr=%02h, required 1 01", o_done, o_addr);
    else n_pass++;
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int w0;
    send_frame(1, 16'h1234, 16'h0000, 1'b0);
    n_total++;
    if (o_done !== 1'b1 || o_err !== 1'b0 || o_cpu_rst !== 1'b0)
      $display("FAIL chk_good: got done=%0b err=%0b cpu_rst=%0b, required 1 0 0", o_done, o_err, o_cpu_rst);
    else n_pass++;
    w0 = n_writes;
    send_frame(1, 16'h1234, 16'h0000, 1'b1);
    n_total++;
    if (o_err !== 1'b1 || o_done !== 1'b0 || o_cpu_rst !== 1'b1 || o_busy !== 1'b0 || n_writes !== w0 + 1)
      $display("FAIL chk_bad: got err=%0b done=%0b cpu_rst=%0b busy=%0b writes=%0d, required 1 0 1 0 1",
               o_err, o_done, o_cpu_rst, o_busy, n_writes - w0);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass   = 0;
    n_total  = 0;
    n_writes = 0;
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_byte   = 8'h00;
    test_reset();
    test_basic();
    test_garbage();
    test_full256();
    test_stall();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that writes 16-bit instruction words into the CPU instruction memory through the CPU's instr/we write port.
- Holds the CPU in reset while a program is loading and releases it once the load completes.
- Sits between a byte source (UART receiver or bench driver) and the CPU.
- Acts as the writer side of the CPU's instruction-load interface.

Parameters:
- ADDR_W, 8, instruction memory address width; must be >= 8.
- HDR_BYTE, 8'hA5, start-of-frame marker byte.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_byte  input  8  incoming stream byte.
- i_valid  input  1  i_byte is valid this cycle.
- o_ready  output  1  loader accepts i_byte this cycle; a transfer occurs when i_valid && o_ready.
- o_instr  output  16  instruction word to the CPU.
- o_we  output  1  instruction write strobe to the CPU, one-cycle pulse.
- o_addr  output  ADDR_W  word address of the current write.
- o_cpu_rst  output  1  active-high CPU reset.
- o_busy  output  1  a frame is in progress.
- o_done  output  1  the last frame loaded successfully (level).
- o_err  output  1  the last frame failed (level).

Behaviour:
- Frame format: HDR_BYTE, then count byte N (0 encodes 256 words), then 2N data bytes. Each word is sent high byte first.
- Reset values (i_rst_n low, asynchronous):
  - State = IDLE.
  - o_instr = 0, o_we = 0, o_addr = 0.
  - o_cpu_rst = 1.
  - o_busy = 0, o_done = 0, o_err = 0.
  - Word counter = 0.
- States:
  - IDLE: o_ready = 1. Non-header bytes are discarded. HDR_BYTE goes to CNT and sets o_busy = 1, o_cpu_rst = 1, o_done = 0, o_err = 0, o_addr = 0.
  - CNT: o_ready = 1. Latch N (0 becomes 256), then go to HI.
  - HI: o_ready = 1. Latch the byte into o_instr[15:8], then go to LO.
  - LO: o_ready = 1. Latch the byte into o_instr[7:0], then go to WRITE.
  - WRITE: o_ready = 0. Lasts exactly one cycle with o_we = 1; o_instr and o_addr are stable during it. On exit, o_addr increments and the word counter decrements. If the counter reaches 0, go to DONE (or CHK when the optional feature is compiled in); otherwise go to HI.
  - DONE: o_ready = 1, o_busy = 0, o_done = 1, o_cpu_rst = 0. HDR_BYTE restarts a frame as in IDLE; any other byte is ignored.
  - ERR: o_ready = 1, o_busy = 0, o_err = 1, o_cpu_rst = 1. HDR_BYTE restarts; any other byte is ignored.
- Latency:
  - LO byte accepted at edge t: o_we is high during cycle t+1.
  - Last WRITE: o_done rises and o_cpu_rst falls one cycle later.
- Inside a frame, a byte equal to HDR_BYTE is treated as data, not as a resync.
- i_valid low stalls any state except WRITE; no timeout.
- o_addr wraps modulo 2^ADDR_W. With N = 256 and ADDR_W = 8, the final address is 255 and o_addr then wraps to 0.
- Asynchronous reset mid-frame aborts immediately; o_we is never left high.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - The frame carries one extra byte after the data: the 8-bit modulo-256 sum of all 2N data bytes.
  - State CHK (o_ready = 1) compares the received byte against the running sum, which is cleared on HDR_BYTE.
  - Match goes to DONE; mismatch goes to ERR, keeping the CPU in reset.
- Disabled: no CHK state and no sum register; the last WRITE goes directly to DONE, and ERR is unreachable (o_err tied 0).

Test Plan:
- Reset, then send A5 02 12 34 AB CD with i_valid held high → o_we pulses at addr 0 with 16'h1234 and at addr 1 with 16'hABCD. Next cycle o_done = 1, o_cpu_rst = 0, o_busy = 0.
- Garbage 00 FF 5A before A5 01 00 07 → garbage ignored; a single write of 16'h0007 at addr 0.
- A5 00 followed by 512 bytes → 256 writes at addresses 0..255; o_addr ends at 0 and o_done = 1.
- Drop i_valid low for 5 cycles between the HI and LO bytes → no o_we until the LO byte arrives; o_instr holds its high byte.
- Assert i_rst_n low mid-frame after 3 data bytes → all outputs return to reset values within the same cycle. A fresh A5 01 11 22 then loads 16'h1122 at addr 0.
- With PROG_LOADER_CHECKSUM_EN defined:
  - A5 01 12 34 46 → o_done = 1.
  - A5 01 12 34 47 → o_err = 1, o_cpu_rst stays 1, and the word was still written.
